// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - pin synchroniser, per-bit debouncer and edge strobes
module gpio_debounce #(
  parameter int              NIN      = 16,
  parameter int              PRESCALE = 1,
  parameter int              STABLE   = 4,
  parameter logic [NIN-1:0]  DEFAULT  = '0
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic [NIN-1:0] i_pins,
  output logic [NIN-1:0] o_gpio,
  output logic [NIN-1:0] o_rise,
  output logic [NIN-1:0] o_fall,
  output logic           o_change
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  // A bit flips on the tick that would take its count to STABLE.
  localparam logic [CW-1:0] C_LAST = CW'(STABLE - 1);

  logic [NIN-1:0] s1;
  logic [NIN-1:0] s2;
  logic [PW-1:0]  pcnt;
  logic           tick;
  logic [CW-1:0]  cnt    [NIN];
  logic [CW-1:0]  cnt_nx [NIN];
  logic [NIN-1:0] gpio_nx;
  logic [NIN-1:0] rise_nx;
  logic [NIN-1:0] fall_nx;

  // Two-flop synchroniser; s2 is the only view of the pads used downstream.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1 <= DEFAULT;
      s2 <= DEFAULT;
    end else begin
      s1 <= i_pins;
      s2 <= s1;
    end
  end

  // Sample-rate prescaler; with PRESCALE=1 it stays at 0 and tick is always set.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick = (pcnt == P_LAST);

  // Per-bit stability counters and the next debounced value / edge strobes.
  always_comb begin
    gpio_nx = o_gpio;
    rise_nx = '0;
    fall_nx = '0;
    for (int i = 0; i < NIN; i++) begin
      cnt_nx[i] = cnt[i];
      if (tick) begin
        if (s2[i] == o_gpio[i]) begin
          cnt_nx[i] = '0;
        end else if (cnt[i] == C_LAST) begin
          gpio_nx[i] = s2[i];
          cnt_nx[i]  = '0;
          rise_nx[i] = s2[i];
          fall_nx[i] = ~s2[i];
        end else begin
          cnt_nx[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Register debounced state, counters and single-cycle strobes together.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_gpio   <= DEFAULT;
      o_rise   <= '0;
      o_fall   <= '0;
      o_change <= 1'b0;
      for (int i = 0; i < NIN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      o_gpio   <= gpio_nx;
      o_rise   <= rise_nx;
      o_fall   <= fall_nx;
      o_change <= |(rise_nx | fall_nx);
      for (int i = 0; i < NIN; i++) begin
        cnt[i] <= cnt_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// tb/tb_gpio_debounce.sv - randomized bench for gpio_debounce with a sliding-window model
module tb_gpio_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] pins0, pins1;
  logic [7:0]  pins2;
  logic [15:0] g0, r0, f0, g1, r1, f1;
  logic [7:0]  g2, r2, f2;
  logic        c0, c1, c2;

  gpio_debounce #(.NIN(16), .PRESCALE(1), .STABLE(4), .DEFAULT(16'h0000)) u0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_pins(pins0),
    .o_gpio(g0), .o_rise(r0), .o_fall(f0), .o_change(c0));

  gpio_debounce #(.NIN(16), .PRESCALE(10), .STABLE(3), .DEFAULT(16'h0000)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_pins(pins1),
    .o_gpio(g1), .o_rise(r1), .o_fall(f1), .o_change(c1));

  gpio_debounce #(.NIN(8), .PRESCALE(3), .STABLE(1), .DEFAULT(8'h01)) u2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_pins(pins2),
    .o_gpio(g2), .o_rise(r2), .o_fall(f2), .o_change(c2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a bit flips when its last STABLE tick samples all differ from it.
  int          mp   [3] = '{1, 10, 3};
  int          ms   [3] = '{4, 3, 1};
  logic [15:0] mdef [3] = '{16'h0000, 16'h0000, 16'h0001};
  logic [15:0] mmsk [3] = '{16'hFFFF, 16'hFFFF, 16'h00FF};
  logic [15:0] d1 [3], d2 [3], st [3], er [3], ef [3];
  logic        ech [3];
  int          ecnt [3];
  int          nsamp [3];
  logic [15:0] win [3][16];

  function automatic logic [15:0] pin_of(input int k);
    case (k)
      0:       return pins0;
      1:       return pins1;
      default: return {8'h00, pins2};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      d1[k] = mdef[k]; d2[k] = mdef[k]; st[k] = mdef[k];
      er[k] = '0; ef[k] = '0; ech[k] = 1'b0;
      ecnt[k] = 0; nsamp[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    logic [15:0] seen;
    logic        tck, all_diff;
    seen  = d2[k];                     // pad value from two edges ago
    d2[k] = d1[k];
    d1[k] = pin_of(k) & mmsk[k];
    tck   = (ecnt[k] % mp[k]) == mp[k] - 1;
    ecnt[k]++;
    er[k] = '0;
    ef[k] = '0;
    if (tck) begin
      for (int j = 15; j > 0; j--) win[k][j] = win[k][j-1];
      win[k][0] = seen;
      if (nsamp[k] < 16) nsamp[k]++;
      for (int b = 0; b < 16; b++) begin
        if (mmsk[k][b] && nsamp[k] >= ms[k]) begin
          all_diff = 1'b1;
          for (int j = 0; j < ms[k]; j++)
            if (win[k][j][b] == st[k][b]) all_diff = 1'b0;
          if (all_diff) begin
            st[k][b] = ~st[k][b];
            er[k][b] = st[k][b];
            ef[k][b] = ~st[k][b];
          end
        end
      end
    end
    ech[k] = |(er[k] | ef[k]);
  endtask

  task automatic check_all();
    check("u0_gpio", {16'h0, g0}, {16'h0, st[0]});
    check("u0_rise", {16'h0, r0}, {16'h0, er[0]});
    check("u0_fall", {16'h0, f0}, {16'h0, ef[0]});
    check("u0_change", {31'h0, c0}, {31'h0, ech[0]});
    check("u1_gpio", {16'h0, g1}, {16'h0, st[1]});
    check("u1_rise", {16'h0, r1}, {16'h0, er[1]});
    check("u1_fall", {16'h0, f1}, {16'h0, ef[1]});
    check("u1_change", {31'h0, c1}, {31'h0, ech[1]});
    check("u2_gpio", {24'h0, g2}, {24'h0, st[2][7:0]});
    check("u2_rise", {24'h0, r2}, {24'h0, er[2][7:0]});
    check("u2_fall", {24'h0, f2}, {24'h0, ef[2][7:0]});
    check("u2_change", {31'h0, c2}, {31'h0, ech[2]});
  endtask

  // One clock: model advances on the edge, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    check_all();
  endtask

  int lat, pulses;
  logic [15:0] cap_r, cap_f;

  initial begin
    rst_n = 1'b0;
    pins0 = '0; pins1 = '0; pins2 = 8'h01;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();

    // Clean rising edge on u0 pin 0
    pins0[0] = 1'b1;
    lat = 0; pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (g0[0] && lat == 0) lat = c;
      if (c0) pulses++;
    end
    check("t1_latency", lat, 6);
    check("t1_change_pulses", pulses, 1);

    // 3-cycle glitch on u0 pin 3
    pins0[3] = 1'b1;
    repeat (3) cycle();
    pins0[3] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (c0) pulses++;
    end
    check("t2_glitch_pulses", pulses, 0);

    // Slow-sampled falling edge on u1 pin 1, launched at a fixed tick phase
    pins1[1] = 1'b1;
    repeat (60) cycle();
    for (int c = 0; c < 10 && (ecnt[1] % 10) != 8; c++) cycle();
    check("t3_phase", ecnt[1] % 10, 8);
    pins1[1] = 1'b0;
    lat = 0; pulses = 0;
    for (int c = 1; c <= 45; c++) begin
      cycle();
      if (!g1[1] && lat == 0) lat = c;
      if (f1[1]) pulses++;
    end
    check("t3_latency", lat, 32);
    check("t3_in_window", (lat >= 28 && lat <= 40) ? 1 : 0, 1);
    check("t3_fall_pulses", pulses, 1);

    // All 16 bits swap at once on u0
    pins0 = 16'h00FF;
    repeat (10) cycle();
    pins0 = 16'hFF00;
    pulses = 0; cap_r = '0; cap_f = '0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (c0) begin
        pulses++;
        cap_r = r0;
        cap_f = f0;
      end
    end
    check("t4_change_pulses", pulses, 1);
    check("t4_rise_vec", cap_r, 16'hFF00);
    check("t4_fall_vec", cap_f, 16'h00FF);

    // Reset in the middle of a count
    pins0[0] = 1'b1;
    repeat (4) cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t5_async_gpio", {16'h0, g0}, 32'h0);
    check_all();
    repeat (2) cycle();
    rst_n = 1'b1;
    lat = 0; pulses = 0;
    for (int c = 1; c <= 14; c++) begin
      cycle();
      if (g0[0] && lat == 0) lat = c;
      if (c2) pulses++;
    end
    check("t5_latency", lat, 6);
    // u2 has DEFAULT bit 0 set and its pin 0 held high through reset
    check("t6_no_change", pulses, 0);
    check("t6_gpio", {24'h0, g2}, 32'h1);

    // Randomized bouncing on all three instances
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) pins0[$urandom_range(15)] ^= 1'b1;
      if ($urandom_range(63) == 0) pins0 = 16'($urandom);
      if ($urandom_range(7) == 0) pins1[$urandom_range(15)] ^= 1'b1;
      if ($urandom_range(63) == 0) pins1 = 16'($urandom);
      if ($urandom_range(5) == 0) pins2[$urandom_range(7)] ^= 1'b1;
      if ($urandom_range(299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
